// File: rtl/filter_window_dma_if.sv
// Memory master and filter master bus bundle for filter_window_dma.
// The DMA side uses the master modport; memory/filter models use slave.
interface filter_window_dma_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [31:0]       mem_readdata;
  logic              mem_waitrequest;

  logic [3:0]        flt_address;
  logic              flt_read;
  logic              flt_write;
  logic [31:0]       flt_writedata;
  logic [31:0]       flt_readdata;
  logic              flt_waitrequest;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_readdata, mem_waitrequest,
    output flt_address, flt_read, flt_write, flt_writedata,
    input  flt_readdata, flt_waitrequest
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_readdata, mem_waitrequest,
    input  flt_address, flt_read, flt_write, flt_writedata,
    output flt_readdata, flt_waitrequest
  );
endinterface

// File: rtl/filter_window_dma.sv
// Walks every interior pixel of an RGB image, feeds its 3x3 window to the
// filter peripheral and stores each 8-bit result to a destination buffer.
module filter_window_dma #(
  parameter int ADDR_W  = 32,
  parameter int DIM_W   = 12,
  parameter int FLT_GAP = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  filter_window_dma_if.master bus,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_MRD, S_FWR, S_GAP, S_FRD, S_MWR, S_NEXT
  } state_t;

  localparam logic [DIM_W-1:0] DIM_1    = DIM_W'(1);
  localparam logic [DIM_W-1:0] DIM_3    = DIM_W'(3);
  localparam logic [7:0]       GAP_LAST = 8'((FLT_GAP > 0) ? FLT_GAP - 1 : 0);
  localparam state_t           FWR_DONE = (FLT_GAP > 0) ? S_GAP : S_FRD;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [DIM_W-1:0]  width_q, width_d, height_q, height_d;
  logic [DIM_W-1:0]  x_q, x_d, y_q, y_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       pix_q, pix_d;
  logic [7:0]        res_q, res_d;
  logic [7:0]        gap_q, gap_d;
  logic [3:0]        k_q, k_d;
  logic              done_q, done_d, err_q, err_d, ie_q, ie_d;

  logic              busy;
  logic              start_req;
  logic [DIM_W-1:0]  x_inc, y_inc;
  logic              row_wrap, last_win;
  logic [ADDR_W-1:0] kr, kc, row, col, pix_addr, res_addr;
  logic              unused_flt;

  assign busy      = (state_q != S_IDLE);
  assign start_req = csr_write && (csr_address == 3'd0) && csr_writedata[0];
  assign irq       = done_q & ie_q;
  assign unused_flt = ^bus.flt_readdata[31:8];

  // Window geometry: neighbour k sits at row y-1+k/3, column x-1+k%3.
  always_comb begin
    kr       = ADDR_W'(k_q / 4'd3);
    kc       = ADDR_W'(k_q % 4'd3);
    row      = ADDR_W'(y_q) + kr - ADDR_W'(1);
    col      = ADDR_W'(x_q) + kc - ADDR_W'(1);
    pix_addr = src_q + ((row * ADDR_W'(width_q) + col) << 2);
    res_addr = dst_q + (ADDR_W'(count_q) << 2);
    x_inc    = x_q + DIM_1;
    y_inc    = y_q + DIM_1;
    row_wrap = (x_inc == width_q - DIM_1);
    last_win = row_wrap && (y_inc == height_q - DIM_1);
  end

  always_comb begin
    csr_readdata = '0;
    if (csr_read) begin
      case (csr_address)
        3'd0:    csr_readdata = {28'h0, err_q, ie_q, done_q, busy};
        3'd1:    csr_readdata = 32'(src_q);
        3'd2:    csr_readdata = 32'(dst_q);
        3'd3:    csr_readdata = 32'(width_q);
        3'd4:    csr_readdata = 32'(height_q);
        3'd5:    csr_readdata = count_q;
        default: csr_readdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      width_q  <= '0;
      height_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
      count_q  <= '0;
      pix_q    <= '0;
      res_q    <= '0;
      gap_q    <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ie_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      width_q  <= width_d;
      height_q <= height_d;
      x_q      <= x_d;
      y_q      <= y_d;
      count_q  <= count_d;
      pix_q    <= pix_d;
      res_q    <= res_d;
      gap_q    <= gap_d;
      k_q      <= k_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ie_q     <= ie_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    width_d  = width_q;
    height_d = height_q;
    x_d      = x_q;
    y_d      = y_q;
    count_d  = count_q;
    pix_d    = pix_q;
    res_d    = res_q;
    gap_d    = gap_q;
    k_d      = k_q;
    done_d   = done_q;
    err_d    = err_q;
    ie_d     = ie_q;

    bus.mem_address   = '0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_writedata = '0;
    bus.flt_address   = '0;
    bus.flt_read      = 1'b0;
    bus.flt_write     = 1'b0;
    bus.flt_writedata = '0;

    if (csr_write && (csr_address == 3'd0)) begin
      ie_d = csr_writedata[2];
      if (csr_writedata[1]) done_d = 1'b0;
    end
    if (csr_write && !busy) begin
      case (csr_address)
        3'd1:    src_d    = ADDR_W'(csr_writedata);
        3'd2:    dst_d    = ADDR_W'(csr_writedata);
        3'd3:    width_d  = csr_writedata[DIM_W-1:0];
        3'd4:    height_d = csr_writedata[DIM_W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          count_d = '0;
          if (width_q < DIM_3 || height_q < DIM_3) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            done_d  = 1'b0;
            err_d   = 1'b0;
            x_d     = DIM_1;
            y_d     = DIM_1;
            k_d     = '0;
            state_d = S_MRD;
          end
        end
      end
      S_MRD: begin
        bus.mem_read    = 1'b1;
        bus.mem_address = pix_addr;
        if (!bus.mem_waitrequest) begin
          pix_d   = bus.mem_readdata;
          state_d = S_FWR;
        end
      end
      S_FWR: begin
        bus.flt_write     = 1'b1;
        bus.flt_address   = k_q;
        bus.flt_writedata = pix_q;
        if (!bus.flt_waitrequest) begin
          if (k_q == 4'd8) begin
            gap_d   = '0;
            state_d = FWR_DONE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = S_MRD;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_FRD;
        else                   gap_d   = gap_q + 8'd1;
      end
      S_FRD: begin
        bus.flt_read = 1'b1;
        if (!bus.flt_waitrequest) begin
          res_d   = bus.flt_readdata[7:0];
          state_d = S_MWR;
        end
      end
      S_MWR: begin
        bus.mem_write     = 1'b1;
        bus.mem_address   = res_addr;
        bus.mem_writedata = {24'h0, res_q};
        if (!bus.mem_waitrequest) begin
          count_d = count_q + 32'd1;
          // Final window finishes here so done is visible right after the last write.
          if (last_win) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        k_d     = '0;
        state_d = S_MRD;
        if (row_wrap) begin
          x_d = DIM_1;
          y_d = y_inc;
        end else begin
          x_d = x_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_filter_window_dma.sv
// Bench for filter_window_dma: mock memory and filter slaves, a window-walk
// reference model, randomized images, dimensions and stalls.
module tb_filter_window_dma;
  localparam int ADDR_W   = 32;
  localparam int DIM_W    = 12;
  localparam int FLT_GAP  = 2;
  localparam int RD_STALL = 3;

  typedef logic [31:0] win_t [9];
  typedef struct { logic [31:0] a; logic [31:0] d; } xfer_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_address;
  logic        csr_read, csr_write;
  logic [31:0] csr_writedata, csr_readdata;
  logic        irq;

  always #5 clk = ~clk;

  filter_window_dma_if #(.ADDR_W(ADDR_W)) bus ();

  filter_window_dma #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .FLT_GAP(FLT_GAP)) dut (
    .clk(clk), .reset(reset),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .bus(bus), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ffun(input win_t p);
    logic [7:0] s;
    s = 8'h00;
    for (int k = 0; k < 9; k++) s = s + 8'(k + 1) * (p[k][7:0] ^ p[k][15:8]) + p[k][23:16];
    return s;
  endfunction

  // Memory model: combinational read, random stall per transfer.
  logic [31:0] mem [0:4095];
  int          mwait = 0;
  bit          rand_stall = 1'b0;
  assign bus.mem_readdata    = mem[bus.mem_address[13:2]];
  assign bus.mem_waitrequest = (bus.mem_read || bus.mem_write) && (mwait != 0);
  always @(posedge clk) begin
    if (bus.mem_read || bus.mem_write) begin
      if (mwait != 0) mwait <= mwait - 1;
      else            mwait <= rand_stall ? int'($urandom_range(0, 4)) : 0;
    end
  end

  // Filter model: latches pixels 0..8, read stalls RD_STALL cycles.
  win_t fregs;
  int   fwwait, frwait;
  bit   flt_fixed = 1'b0;
  assign bus.flt_readdata    = {24'h0, flt_fixed ? 8'h5A : ffun(fregs)};
  assign bus.flt_waitrequest = (bus.flt_write && fwwait != 0) || (bus.flt_read && frwait != 0);
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      fwwait <= 0;
      frwait <= RD_STALL;
    end else begin
      if (bus.flt_write) begin
        if (fwwait != 0) fwwait <= fwwait - 1;
        else begin
          if (bus.flt_address < 4'd9) fregs[bus.flt_address] <= bus.flt_writedata;
          fwwait <= rand_stall ? int'($urandom_range(0, 2)) : 0;
        end
      end
      if (bus.flt_read) begin
        if (frwait != 0) frwait <= frwait - 1;
        else             frwait <= RD_STALL;
      end
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic [31:0]  mrd_q[$];
  xfer_t        mwr_q[$], fwr_q[$];
  int           frd_n = 0, strobe_cycles = 0, since8 = 0;
  bit           prev_stall = 1'b0, gap_armed = 1'b0;
  logic [103:0] cur_v, prev_v;
  logic [3:0]   strb;

  always @(negedge clk) begin
    cur_v = {bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata,
             bus.flt_read, bus.flt_write, bus.flt_address, bus.flt_writedata};
    strb  = {bus.mem_read, bus.mem_write, bus.flt_read, bus.flt_write};
    if (reset) begin
      prev_stall = 1'b0;
      gap_armed  = 1'b0;
    end else begin
      since8++;
      if (strb != 4'b0) begin
        strobe_cycles++;
        check("one_strobe", 128'($countones(strb) <= 1), 128'(1));
      end
      if (prev_stall) check("hold_stable", 128'(cur_v), 128'(prev_v));
      if (bus.mem_read && !bus.mem_waitrequest) mrd_q.push_back(bus.mem_address);
      if (bus.mem_write && !bus.mem_waitrequest) mwr_q.push_back('{bus.mem_address, bus.mem_writedata});
      if (bus.flt_write && !bus.flt_waitrequest) begin
        fwr_q.push_back('{32'(bus.flt_address), bus.flt_writedata});
        if (bus.flt_address == 4'd8) begin
          since8    = 0;
          gap_armed = 1'b1;
        end
      end
      if (bus.flt_read && gap_armed) begin
        check("flt_gap", 128'(since8 - 1), 128'(FLT_GAP));
        gap_armed = 1'b0;
      end
      if (bus.flt_read && !bus.flt_waitrequest) frd_n++;
      prev_stall = ((bus.mem_read || bus.mem_write) && bus.mem_waitrequest) ||
                   ((bus.flt_read || bus.flt_write) && bus.flt_waitrequest);
      prev_v = cur_v;
    end
  end

  // Reference model: plain loops over interior pixels in raster order.
  logic [31:0] exp_mrd[$];
  xfer_t       exp_mwr[$], exp_fwr[$], saved_mwr[$];

  task automatic build_ref(input int unsigned src, dst, w, h);
    win_t        p;
    logic [31:0] a;
    int unsigned n = 0;
    exp_mrd.delete(); exp_mwr.delete(); exp_fwr.delete();
    for (int y = 1; y <= int'(h) - 2; y++)
      for (int x = 1; x <= int'(w) - 2; x++) begin
        for (int k = 0; k < 9; k++) begin
          a    = src + 4 * ((y - 1 + k / 3) * w + (x - 1 + k % 3));
          p[k] = mem[a[13:2]];
          exp_mrd.push_back(a);
          exp_fwr.push_back('{32'(k), p[k]});
        end
        exp_mwr.push_back('{dst + 4 * n, {24'h0, flt_fixed ? 8'h5A : ffun(p)}});
        n++;
      end
  endtask

  task automatic clear_logs();
    mrd_q.delete(); mwr_q.delete(); fwr_q.delete();
    frd_n = 0;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    @(negedge clk);
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    csr_address = a; csr_read = 1'b1;
    #1 d = csr_readdata;
    csr_read = 1'b0;
  endtask

  task automatic program_job(input int unsigned src, dst, w, h);
    csr_wr(3'd1, src); csr_wr(3'd2, dst); csr_wr(3'd3, w); csr_wr(3'd4, h);
  endtask

  task automatic fill_image();
    for (int i = 0; i < 1024; i++) mem[i] = {8'h00, 24'($urandom)};
  endtask

  task automatic start_job(input string tag, input int unsigned src, dst, w, h);
    logic [31:0] v;
    clear_logs();
    build_ref(src, dst, w, h);
    program_job(src, dst, w, h);
    csr_wr(3'd0, 32'h7);
    csr_address = 3'd0; csr_read = 1'b1;
    #1 v = csr_readdata;
    csr_read = 1'b0;
    check({tag, "_busy"}, 128'(v[0]), 128'(1));
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_nrd"},  128'(mrd_q.size()), 128'(exp_mrd.size()));
    check({tag, "_nfwr"}, 128'(fwr_q.size()), 128'(exp_fwr.size()));
    check({tag, "_nfrd"}, 128'(frd_n),        128'(exp_mwr.size()));
    check({tag, "_nwr"},  128'(mwr_q.size()), 128'(exp_mwr.size()));
    for (int i = 0; i < mrd_q.size() && i < exp_mrd.size(); i++)
      check({tag, "_rd_addr"}, 128'(mrd_q[i]), 128'(exp_mrd[i]));
    for (int i = 0; i < fwr_q.size() && i < exp_fwr.size(); i++)
      check({tag, "_fwr"}, {fwr_q[i].a, fwr_q[i].d}, {exp_fwr[i].a, exp_fwr[i].d});
    for (int i = 0; i < mwr_q.size() && i < exp_mwr.size(); i++)
      check({tag, "_wr"}, {mwr_q[i].a, mwr_q[i].d}, {exp_mwr[i].a, exp_mwr[i].d});
  endtask

  task automatic finish_job(input string tag);
    logic [31:0] v;
    v = '0;
    for (int n = 0; n < 20000 && !v[1]; n++) csr_rd(3'd0, v);
    check({tag, "_done_seen"}, 128'(v[1]), 128'(1));
    csr_rd(3'd0, v);
    check({tag, "_ctrl"}, 128'(v[3:0]), 128'(4'b0110));
    csr_rd(3'd5, v);
    check({tag, "_count"}, 128'(v), 128'(exp_mwr.size()));
    check({tag, "_irq"}, 128'(irq), 128'(1));
    compare_logs(tag);
  endtask

  task automatic run_job(input string tag, input int unsigned src, dst, w, h);
    start_job(tag, src, dst, w, h);
    finish_job(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          sc;
    reset = 1'b1; csr_address = '0; csr_read = 1'b0; csr_write = 1'b0; csr_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_bus", 128'({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata,
                           bus.flt_read, bus.flt_write, bus.flt_address, bus.flt_writedata}), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    #2 reset = 1'b0;
    csr_rd(3'd0, v); check("rst_ctrl", 128'(v), 128'(0));
    csr_rd(3'd5, v); check("rst_count", 128'(v), 128'(0));
    csr_rd(3'd3, v); check("rst_width", 128'(v), 128'(0));

    // 3x3 image, fixed filter result.
    for (int k = 0; k < 9; k++) mem[k] = {8'h00, 8'(k), 8'(k), 8'(k)};
    flt_fixed = 1'b1;
    run_job("t1", 32'h0, 32'h1000, 3, 3);
    check("t1_fwr8", 128'(fwr_q[8].d), 128'(32'h00080808));
    check("t1_wr0", {mwr_q[0].a, mwr_q[0].d}, {32'h1000, 32'h5A});
    flt_fixed = 1'b0;

    // 5x4 image, zero wait; window (2,2) pixel 0 at SRC+4*6.
    fill_image();
    run_job("t2", 32'h100, 32'h2000, 5, 4);
    check("t2_win22_p0", 128'(mrd_q[36]), 128'(32'h100 + 24));
    saved_mwr = mwr_q;

    // Same job with random stalls must give identical results.
    rand_stall = 1'b1;
    run_job("t4", 32'h100, 32'h2000, 5, 4);
    check("t4_nsame", 128'(mwr_q.size()), 128'(saved_mwr.size()));
    for (int i = 0; i < mwr_q.size() && i < saved_mwr.size(); i++)
      check("t4_same", {mwr_q[i].a, mwr_q[i].d}, {saved_mwr[i].a, saved_mwr[i].d});

    // Degenerate dimensions.
    program_job(32'h0, 32'h2000, 2, 5);
    sc = strobe_cycles;
    csr_wr(3'd0, 32'h7);
    repeat (3) @(negedge clk);
    csr_rd(3'd0, v); check("t3_ctrl", 128'(v[3:0]), 128'(4'b1110));
    csr_rd(3'd5, v); check("t3_count", 128'(v), 128'(0));
    check("t3_no_traffic", 128'(strobe_cycles), 128'(sc));
    check("t3_irq", 128'(irq), 128'(1));
    csr_wr(3'd0, 32'h2);
    csr_rd(3'd0, v); check("t3_w1c", 128'(v[3:0]), 128'(4'b1000));
    check("t3_irq_off", 128'(irq), 128'(0));

    // Start and SRC_BASE write while busy are ignored.
    fill_image();
    start_job("t5", 32'h40, 32'h2000, 6, 5);
    repeat (5) @(negedge clk);
    csr_wr(3'd0, 32'h7);
    csr_wr(3'd1, 32'h300);
    csr_rd(3'd1, v); check("t5_src_kept", 128'(v), 128'(32'h40));
    finish_job("t5");

    // Reset during the filter read of window 2, then a clean rerun.
    rand_stall = 1'b0;
    start_job("t6", 32'h80, 32'h2000, 4, 4);
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (bus.flt_read && mwr_q.size() == 1) break;
    end
    check("t6_reached_frd", 128'({bus.flt_read, 32'(mwr_q.size())}), 128'({1'b1, 32'd1}));
    #1 reset = 1'b1;
    csr_address = 3'd5; csr_read = 1'b1;
    #1;
    check("t6_rst_bus", 128'({bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_writedata,
                              bus.flt_read, bus.flt_write, bus.flt_address, bus.flt_writedata}), 128'(0));
    check("t6_rst_irq", 128'(irq), 128'(0));
    check("t6_rst_csr", 128'(csr_readdata), 128'(0));
    @(negedge clk);
    #2 reset = 1'b0;
    csr_read = 1'b0;
    csr_rd(3'd0, v); check("t6_ctrl", 128'(v), 128'(0));
    csr_rd(3'd5, v); check("t6_count", 128'(v), 128'(0));
    run_job("t6_rerun", 32'h80, 32'h2000, 4, 4);

    // Random dimensions, placement and stalls.
    rand_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fill_image();
      run_job("rand", $urandom_range(0, 255) * 4, 32'h2000, $urandom_range(3, 7), $urandom_range(3, 6));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
